// File: rtl/rm_bit_selector_if.sv
// Port bundle for rm_bit_selector: start/config, circular-buffer read port, bit stream out.
// The null_cnt signal exists only when RM_NULL_COUNT_EN is defined.
interface rm_bit_selector_if #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned E_W    = 16
);
    logic              start;
    logic [E_W-1:0]    cfg_e;
    logic [ADDR_W-1:0] cfg_k0;
    logic [ADDR_W-1:0] cfg_ncb;
    logic              busy;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_data;
    logic              rd_null;
    logic              out_bit;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              done;
    logic              err;
`ifdef RM_NULL_COUNT_EN
    logic [ADDR_W-1:0] null_cnt;

    modport slave (
        input  start, cfg_e, cfg_k0, cfg_ncb, rd_data, rd_null, out_ready,
        output busy, rd_en, rd_addr, out_bit, out_valid, out_last, done, err, null_cnt
    );
    modport master (
        output start, cfg_e, cfg_k0, cfg_ncb, rd_data, rd_null, out_ready,
        input  busy, rd_en, rd_addr, out_bit, out_valid, out_last, done, err, null_cnt
    );
`else
    modport slave (
        input  start, cfg_e, cfg_k0, cfg_ncb, rd_data, rd_null, out_ready,
        output busy, rd_en, rd_addr, out_bit, out_valid, out_last, done, err
    );
    modport master (
        output start, cfg_e, cfg_k0, cfg_ncb, rd_data, rd_null, out_ready,
        input  busy, rd_en, rd_addr, out_bit, out_valid, out_last, done, err
    );
`endif
endinterface

// File: rtl/rm_bit_selector.sv
// Rate-matching bit selector: walks the circular buffer from k0, prunes NULL entries, streams E bits.
// Optional RM_NULL_COUNT_EN adds a dropped-NULL counter output (null_cnt).
module rm_bit_selector #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned E_W    = 16,
    parameter int unsigned FIFO_D = 2
) (
    input logic              clk,
    input logic              rst,
    rm_bit_selector_if.slave bus
);
    localparam int unsigned PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_D + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, FIN} state_t;

    state_t            state_q, state_d;
    logic [E_W-1:0]    e_q, pushed_q, sent_q;
    logic [ADDR_W-1:0] ncb_q, addr_q, null_run_q;
    logic              rd_pend_q, err_q, busy_q, done_q;
    logic [FIFO_D-1:0] fifo_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic              active, start_ok, cfg_fault, out_valid, pop, push;
    logic              ret_null, ret_data, null_abort, last_hs, rd_issue;
    logic [OCC_W-1:0]  occ, lim;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign active     = (state_q == RUN) || (state_q == FLUSH);
    assign start_ok   = (state_q == IDLE) && bus.start;
    assign cfg_fault  = (bus.cfg_ncb == '0) || (bus.cfg_k0 >= bus.cfg_ncb);
    assign out_valid  = (count_q != '0);
    assign pop        = out_valid && bus.out_ready;
    assign last_hs    = pop && (sent_q == e_q - E_W'(1));
    assign ret_null   = active && rd_pend_q && bus.rd_null;
    assign ret_data   = active && rd_pend_q && !bus.rd_null;
    assign push       = ret_data && (pushed_q < e_q);
    assign null_abort = (state_q == RUN) && ret_null && ((null_run_q + ADDR_W'(1)) == ncb_q);

    // Reserve FIFO room for the read in flight plus the one issued now; a pop this cycle frees a slot,
    // which is what lets FIFO_D=2 sustain one bit per clock.
    assign occ      = OCC_W'(count_q) + OCC_W'(rd_pend_q);
    assign lim      = OCC_W'(FIFO_D) + OCC_W'(pop);
    assign rd_issue = (state_q == RUN) && (pushed_q < e_q) && !null_abort && (occ < lim);

    assign bus.rd_en     = rd_issue;
    assign bus.rd_addr   = addr_q;
    assign bus.out_valid = out_valid;
    assign bus.out_bit   = out_valid & fifo_q[rd_ptr_q];
    assign bus.out_last  = out_valid && (sent_q == e_q - E_W'(1));
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = ((bus.cfg_e == '0) || cfg_fault) ? FIN : RUN;
            RUN: begin
                if (null_abort || last_hs)  state_d = FIN;
                else if (pushed_q == e_q)   state_d = FLUSH;
            end
            FLUSH:   if (last_hs) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Config latch, read address walk, counters and the output skid FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            e_q        <= '0;
            ncb_q      <= '0;
            addr_q     <= '0;
            pushed_q   <= '0;
            sent_q     <= '0;
            null_run_q <= '0;
            rd_pend_q  <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fifo_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            rd_pend_q <= rd_issue;
            busy_q    <= (state_d == RUN) || (state_d == FLUSH);
            done_q    <= (state_d == FIN);
            if (start_ok) begin
                e_q        <= bus.cfg_e;
                ncb_q      <= bus.cfg_ncb;
                addr_q     <= bus.cfg_k0;
                pushed_q   <= '0;
                sent_q     <= '0;
                null_run_q <= '0;
                err_q      <= (bus.cfg_e != '0) && cfg_fault;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
            end else begin
                if (rd_issue)
                    addr_q <= (addr_q == ncb_q - ADDR_W'(1)) ? '0 : addr_q + ADDR_W'(1);
                if (ret_null)      null_run_q <= null_run_q + ADDR_W'(1);
                else if (ret_data) null_run_q <= '0;
                if (push) pushed_q <= pushed_q + E_W'(1);
                if (pop)  sent_q   <= sent_q + E_W'(1);
                if (null_abort) begin
                    err_q    <= 1'b1;
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    if (push) begin
                        fifo_q[wr_ptr_q] <= bus.rd_data;
                        wr_ptr_q         <= ptr_inc(wr_ptr_q);
                    end
                    if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
                    if (push && !pop)      count_q <= count_q + CNT_W'(1);
                    else if (pop && !push) count_q <= count_q - CNT_W'(1);
                end
            end
        end
    end

`ifdef RM_NULL_COUNT_EN
    logic [ADDR_W-1:0] null_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)           null_cnt_q <= '0;
        else if (start_ok) null_cnt_q <= '0;
        else if (ret_null) null_cnt_q <= null_cnt_q + ADDR_W'(1);
    end

    assign bus.null_cnt = null_cnt_q;
`endif

endmodule

// File: tb/tb_rm_bit_selector.sv
// Directed table-driven bench for rm_bit_selector with a behavioural circular-buffer read port.
module tb_rm_bit_selector;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned E_W    = 16;
    localparam int unsigned FIFO_D = 2;

    typedef struct {
        int k0;
        int ncb;
        int e;
        int nlo;
        int nhi;
        int rmode;
        int exp_n;
        int exp_err;
        int exp_reads;
        int exp_nulls;
        int exp_first_valid;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    rm_bit_selector_if #(.ADDR_W(ADDR_W), .E_W(E_W)) bus();

    rm_bit_selector #(.ADDR_W(ADDR_W), .E_W(E_W), .FIFO_D(FIFO_D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int                checks   = 0;
    int                failures = 0;
    int                cur_nlo  = 1;
    int                cur_nhi  = 0;
    logic              cap_en   = 1'b0;
    logic [ADDR_W-1:0] cap_addr = '0;
    vec_t              vecs[8];

    function automatic logic bitf(input int a);
        return (((a * 37) + (a >>> 3)) % 5) < 2;
    endfunction

    function automatic logic nullf(input int a);
        return (a >= cur_nlo) && (a <= cur_nhi);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_idle_zero(input string name);
        logic [7:0] v;
        v = {bus.busy, bus.rd_en, bus.out_bit, bus.out_valid, bus.out_last,
             bus.done, bus.err, (bus.rd_addr != '0)};
        check(name, int'(v), 0);
`ifdef RM_NULL_COUNT_EN
        check({name, "_null_cnt"}, int'(bus.null_cnt), 0);
`endif
    endtask

    // Advance past the next rising edge and drive read-return data and out_ready for the new cycle.
    task automatic drive_next(input int cyc, input int rmode);
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.rd_data = cap_en ? bitf(int'(cap_addr)) : 1'b0;
        bus.rd_null = cap_en ? nullf(int'(cap_addr)) : 1'b0;
        if (rmode == 0 || (cyc % 4) == 0 || (cyc % 4) == 3) bus.out_ready = 1'b1;
        else bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic run_row(input vec_t r, input string tag);
        logic exp_q[$];
        logic got_q[$];
        int   addr_q[$];
        int   a, budget, mism, bad, last_cnt, last_idx, last_hs, done_cnt, done_cyc;
        int   first_valid, stall_bad, cyc;
        logic err_at_done, busy_at_done, prev_stall, prev_bit, prev_last;

        cur_nlo = r.nlo;
        cur_nhi = r.nhi;
        a = r.k0;
        if (r.exp_n > 0 && r.ncb > 0) begin
            for (int s = 0; s < r.ncb * (r.e + 2) && exp_q.size() < r.e; s++) begin
                if (!nullf(a)) exp_q.push_back(bitf(a));
                a = (a == r.ncb - 1) ? 0 : a + 1;
            end
        end

        last_cnt = 0; last_idx = -1; last_hs = -1; done_cnt = 0; done_cyc = -1;
        first_valid = -1; stall_bad = 0; err_at_done = 1'b0; busy_at_done = 1'b0;
        prev_stall = 1'b0; prev_bit = 1'b0; prev_last = 1'b0;
        budget = 8 * r.e + 4 * r.ncb + 40;

        bus.cfg_e     = E_W'(r.e);
        bus.cfg_k0    = ADDR_W'(r.k0);
        bus.cfg_ncb   = ADDR_W'(r.ncb);
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;

        for (cyc = 0; cyc < budget && !(done_cyc >= 0 && cyc > done_cyc + 3); cyc++) begin
            @(negedge clk);
            cap_en   = bus.rd_en;
            cap_addr = bus.rd_addr;
            if (cap_en) addr_q.push_back(int'(cap_addr));
            if (prev_stall && !(bus.out_valid && bus.out_bit == prev_bit && bus.out_last == prev_last))
                stall_bad++;
            if (bus.out_valid && first_valid < 0) first_valid = cyc;
            if (bus.out_valid && bus.out_ready) begin
                got_q.push_back(bus.out_bit);
                if (bus.out_last) begin
                    last_cnt++;
                    if (last_idx < 0) last_idx = got_q.size() - 1;
                end
                last_hs = cyc;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_bit   = bus.out_bit;
            prev_last  = bus.out_last;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc     = cyc;
                    err_at_done  = bus.err;
                    busy_at_done = bus.busy;
                end
            end
            drive_next(cyc + 1, r.rmode);
        end

        check({tag, "_count"}, got_q.size(), r.exp_n);
        mism = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) mism++;
        check({tag, "_bit_mismatches"}, mism, 0);
        check({tag, "_last_cnt"}, last_cnt, (r.exp_n > 0) ? 1 : 0);
        if (r.exp_n > 0) check({tag, "_last_idx"}, last_idx, r.exp_n - 1);
        check({tag, "_done_cnt"}, done_cnt, 1);
        if (r.exp_n > 0) check({tag, "_done_cyc"}, done_cyc, last_hs + 1);
        else if (r.exp_reads == 0) check({tag, "_done_cyc"}, done_cyc, 1);
        check({tag, "_err"}, int'(err_at_done), r.exp_err);
        check({tag, "_busy_at_done"}, int'(busy_at_done), 0);
        a = r.k0;
        bad = 0;
        foreach (addr_q[i]) begin
            if (addr_q[i] != a) bad++;
            a = (a == r.ncb - 1) ? 0 : a + 1;
        end
        check({tag, "_addr_seq"}, bad, 0);
        if (r.exp_reads >= 0) check({tag, "_reads"}, addr_q.size(), r.exp_reads);
        if (r.exp_first_valid >= 0) check({tag, "_first_valid"}, first_valid, r.exp_first_valid);
        if (r.rmode != 0) check({tag, "_stall_stable"}, stall_bad, 0);
`ifdef RM_NULL_COUNT_EN
        check({tag, "_null_cnt"}, int'(bus.null_cnt), r.exp_nulls);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        //           k0  ncb  e    nlo nhi rm  n    err reads nulls 1st
        vecs[0] = '{0,  96,  60,  0,  3,  0,  60,  0,  -1,   4,    7};
        vecs[1] = '{80, 96,  40,  1,  0,  0,  40,  0,  -1,   0,    3};
        vecs[2] = '{80, 96,  40,  1,  0,  1,  40,  0,  -1,   0,   -1};
        vecs[3] = '{0,  96,  200, 10, 15, 0,  200, 0,  -1,   18,   3};
        vecs[4] = '{0,  0,   10,  1,  0,  0,  0,   1,  0,    0,   -1};
        vecs[5] = '{0,  96,  0,   1,  0,  0,  0,   0,  0,    0,   -1};
        vecs[6] = '{5,  96,  10,  0,  95, 0,  0,   1,  96,   96,  -1};
        vecs[7] = '{96, 96,  5,   1,  0,  0,  0,   1,  0,    0,   -1};

        rst = 1'b1;
        bus.start = 1'b0; bus.cfg_e = '0; bus.cfg_k0 = '0; bus.cfg_ncb = '0;
        bus.rd_data = 1'b0; bus.rd_null = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_zero("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_row(vecs[i], $sformatf("row%0d", i));

        // Mid-run reset after 17 bits, with an ignored start pulse while busy.
        begin
            logic got17[$];
            int   hs, mism;
            bit   hit, restarted;
            vec_t rr;
            cur_nlo = 1; cur_nhi = 0;
            hs = 0; hit = 0; restarted = 0;
            bus.cfg_e = E_W'(40); bus.cfg_k0 = ADDR_W'(80); bus.cfg_ncb = ADDR_W'(96);
            bus.start = 1'b1; bus.out_ready = 1'b1;
            for (int cyc = 0; cyc < 300 && !hit; cyc++) begin
                @(negedge clk);
                cap_en   = bus.rd_en;
                cap_addr = bus.rd_addr;
                if (bus.out_valid && bus.out_ready) begin
                    got17.push_back(bus.out_bit);
                    hs++;
                end
                drive_next(cyc + 1, 0);
                if (hs == 5 && !restarted) begin
                    bus.start = 1'b1; bus.cfg_e = E_W'(3); bus.cfg_k0 = '0;
                    restarted = 1;
                end
                if (hs == 17) begin
                    rst = 1'b1;
                    hit = 1;
                end
            end
            check("rst_at_17", hs, 17);
            mism = 0;
            foreach (got17[i]) if (got17[i] !== bitf((80 + i) % 96)) mism++;
            check("pre_rst_bits", mism, 0);
            @(posedge clk);
            #1;
            rst = 1'b0; cap_en = 1'b0; bus.start = 1'b0;
            bus.rd_data = 1'b0; bus.rd_null = 1'b0;
            @(negedge clk);
            check_idle_zero("after_mid_rst");
            @(posedge clk);
            #1;
            rr = '{3, 96, 10, 1, 0, 0, 10, 0, -1, 0, 3};
            run_row(rr, "post_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
